// File: rtl/seg_seq_checker_if.sv
// rtl/seg_seq_checker_if.sv - sampled 7-segment stream into seg_seq_checker
// Carries one qualified segment sample plus the direction of the step that produced it.
interface seg_seq_checker_if;
    logic       valid;
    logic [6:0] seg_in;
    logic       modo;

    modport master (output valid, seg_in, modo);
    modport slave  (input  valid, seg_in, modo);
endinterface

// File: rtl/seg_seq_checker.sv
// rtl/seg_seq_checker.sv - decoder/lock monitor for the scrambled 7-segment up/down counter
// Optional SEGCHK_STUTTER_EN: a repeated sample while acquiring/locked is accepted silently.
module seg_seq_checker #(
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    seg_seq_checker_if.slave   stream,
    output logic [3:0]         digit,
    output logic [3:0]         index,
    output logic               seg_ok,
    output logic               locked,
    output logic               err,
    output logic [ERR_W-1:0]   err_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] good, good_nxt;
    logic [3:0] digit_nxt, index_nxt;
    logic       seg_ok_nxt, err_nxt;

    logic       legal;
    logic [3:0] dec_hex, dec_idx;
    logic [3:0] expected;
    logic       stutter;

    // Pattern -> hex digit and its position in the scrambled up order.
    always_comb begin
        legal   = 1'b1;
        dec_hex = 4'h0;
        dec_idx = 4'd0;
        case (stream.seg_in)
            7'b1101101: begin dec_hex = 4'h2; dec_idx = 4'd0;  end
            7'b1011011: begin dec_hex = 4'h5; dec_idx = 4'd1;  end
            7'b1110000: begin dec_hex = 4'h7; dec_idx = 4'd2;  end
            7'b1111001: begin dec_hex = 4'h3; dec_idx = 4'd3;  end
            7'b1110111: begin dec_hex = 4'hA; dec_idx = 4'd4;  end
            7'b1001111: begin dec_hex = 4'hE; dec_idx = 4'd5;  end
            7'b1111111: begin dec_hex = 4'h8; dec_idx = 4'd6;  end
            7'b1111110: begin dec_hex = 4'h0; dec_idx = 4'd7;  end
            7'b0011111: begin dec_hex = 4'hB; dec_idx = 4'd8;  end
            7'b0110011: begin dec_hex = 4'h4; dec_idx = 4'd9;  end
            7'b1011111: begin dec_hex = 4'h6; dec_idx = 4'd10; end
            7'b0111101: begin dec_hex = 4'hD; dec_idx = 4'd11; end
            7'b1000111: begin dec_hex = 4'hF; dec_idx = 4'd12; end
            7'b0110000: begin dec_hex = 4'h1; dec_idx = 4'd13; end
            7'b1001110: begin dec_hex = 4'hC; dec_idx = 4'd14; end
            7'b1111011: begin dec_hex = 4'h9; dec_idx = 4'd15; end
            default:    legal = 1'b0;
        endcase
    end

    // modo describes the step into this sample, so a reversal just flips the expectation.
    assign expected = stream.modo ? index + 4'd1 : index - 4'd1;

`ifdef SEGCHK_STUTTER_EN
    assign stutter = (dec_idx == index);
`else
    assign stutter = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        good_nxt   = good;
        err_nxt    = 1'b0;
        seg_ok_nxt = seg_ok;
        digit_nxt  = digit;
        index_nxt  = index;
        if (stream.valid) begin
            seg_ok_nxt = legal;
            if (legal) begin
                digit_nxt = dec_hex;
                index_nxt = dec_idx;
            end
            if (state == SEARCH) begin
                if (legal) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = 4'd0;
                end
            end else if (!legal) begin
                err_nxt   = 1'b1;
                state_nxt = SEARCH;
                good_nxt  = 4'd0;
            end else if (stutter) begin
                state_nxt = state;
            end else if (dec_idx == expected) begin
                if (state == ACQUIRE) begin
                    good_nxt = good + 4'd1;
                    if (good_nxt == 4'(LOCK_COUNT))
                        state_nxt = LOCKED;
                end
            end else begin
                // Unexpected legal sample re-seeds the expectation from itself.
                err_nxt   = 1'b1;
                state_nxt = ACQUIRE;
                good_nxt  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            good      <= 4'd0;
            digit     <= 4'h2;
            index     <= 4'd0;
            seg_ok    <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state  <= state_nxt;
            good   <= good_nxt;
            digit  <= digit_nxt;
            index  <= index_nxt;
            seg_ok <= seg_ok_nxt;
            locked <= (state_nxt == LOCKED);
            err    <= err_nxt;
            if (err_nxt && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

endmodule
